vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator. Successor to the fixed 800-clock
//  horizontal counter. Produces the horizontal and vertical counts, HSYNC/VSYNC,
//  the active-video flag and line/frame strobes from one pixel clock.
//  Feeds the pixel pipeline and the DAC/connector pins of the VGA core.
// PARAMETERS
//  H_ACTIVE 640  visible pixels per line
//  H_FP     16   horizontal front porch (pixels)
//  H_SYNC   96   hsync pulse width (pixels)
//  H_BP     48   horizontal back porch (pixels)
//  V_ACTIVE 480  visible lines per frame
//  V_FP     10   vertical front porch (lines)
//  V_SYNC   2    vsync pulse width (lines)
//  V_BP     33   vertical back porch (lines)
//  H_POL    0    hsync active level (0 = active-low)
//  V_POL    0    vsync active level (0 = active-low)
//  CNT_W    16   width of the count outputs
// PORTS
//  clk_25MHz  in   1      pixel clock; all logic on its rising edge
//  rst        in   1      asynchronous, active-high reset
//  pix_en     in   1      pixel advance enable; when low, all state holds
//  h_cnt      out  CNT_W  horizontal position, 0..H_TOTAL-1
//  v_cnt      out  CNT_W  vertical position, 0..V_TOTAL-1
//  hsync      out  1      horizontal sync, polarity per H_POL
//  vsync      out  1      vertical sync, polarity per V_POL
//  video_on   out  1      high when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
//  line_end   out  1      high while h_cnt==H_TOTAL-1
//  frame_end  out  1      high while h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1
//  frame_cnt  out  8      frames completed (present only with VGA_FRAME_CNT_EN)
// BEHAVIOUR
//  - Derived: H_TOTAL = sum of the H_* widths (800 by default); V_TOTAL = sum of the V_* widths (525 by default).
//  - Elaboration error if H_TOTAL-1 or V_TOTAL-1 does not fit in CNT_W bits.
//  - Reset (async, rst=1): h_cnt=0, v_cnt=0, video_on=1, hsync=~H_POL, vsync=~V_POL.
//    Also under reset: line_end=0, frame_end=0, frame_cnt=0.
//  - Every output is a flop. No combinational path from any input to any output.
//  - Decodes are computed from the next count value, so every output describes the
//    same pixel as h_cnt/v_cnt in the same cycle. Zero skew between outputs.
//  - Count update, on a rising edge with pix_en=1:
//    - h_cnt: h_cnt+1; wraps to 0 after H_TOTAL-1.
//    - v_cnt: advances only when h_cnt wraps; wraps to 0 after V_TOTAL-1.
//  - With pix_en=0, counts, strobes and syncs hold their values. Strobes stay high
//    if already high, so consumers qualify them with pix_en.
//  - hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
//  - vsync active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
//  - vsync changes only at h_cnt==0, aligned to the line boundary.
//  - Reset mid-frame: immediate return to (0,0). The next frame starts cleanly; no partial sync pulse is extended.
//  - Deasserting rst: counting resumes on the first pix_en=1 edge after release.
//  - Counter arithmetic is unsigned, CNT_W bits. There is no state beyond the counters, the decode flops and frame_cnt.
// CONFIGURATION
//  - VGA_FRAME_CNT_EN defined:
//    - frame_cnt port present; 8-bit counter.
//    - Increments on the pix_en edge at which (h_cnt,v_cnt) wraps from (H_TOTAL-1,V_TOTAL-1) to (0,0).
//    - Wraps 255->0. Resets to 0.
//  - VGA_FRAME_CNT_EN undefined: frame_cnt port and its logic are absent. All other behaviour is identical.
// TESTING
//  1. rst pulse, then pix_en=1 constantly:
//     - After 799 edges, h_cnt=799 and line_end=1.
//     - Next edge: h_cnt=0, v_cnt=1, line_end=0.
//  2. Default params:
//     - hsync=0 exactly for h_cnt 656..751 (96 clks); 1 elsewhere.
//     - video_on=0 from h_cnt 640 to 799.
//  3. Full frame:
//     - vsync=0 for v_cnt 490..491 (1600 clks).
//     - frame_end=1 for one clk at (799,524).
//     - Frame period 420000 clks.
//  4. pix_en toggled 1,0,1,0:
//     - Counts advance only on pix_en=1 edges; all outputs hold while it is 0.
//     - Line period 1600 clks.
//  5. Assert rst asynchronously at (h_cnt=700, v_cnt=300), between edges:
//     - Outputs take reset values without waiting for a clock edge.
//     - After release, counting restarts from (0,0).
//  6. VGA_FRAME_CNT_EN defined:
//     - frame_cnt goes 0->1 on the wrap edge after (799,524).
//     - Force 255 frames, then the next wrap: frame_cnt=0.
//  Also: rerun 1-3 with H_POL=1, V_POL=1 (inverted sync levels) and a
//  small geometry (H 8/2/2/2, V 4/1/1/1) to check parametrisation.

Source files
------------

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. From one pixel clock it produces
// the horizontal/vertical raster position, HSYNC/VSYNC, the active-video flag
// and the line/frame strobes. Every output is a flop.
//
// Optional feature macro: VGA_FRAME_CNT_EN
//   When defined, an 8-bit frame_cnt output counts completed frames.
//   When undefined, the port and its logic are absent.
//
// Ports
//   clk_25MHz  in   1      pixel clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   pix_en     in   1      pixel advance enable; all state holds while low
//   h_cnt      out  CNT_W  horizontal position, 0..H_TOTAL-1
//   v_cnt      out  CNT_W  vertical position, 0..V_TOTAL-1
//   hsync      out  1      horizontal sync, active level H_POL
//   vsync      out  1      vertical sync, active level V_POL
//   video_on   out  1      inside the visible area
//   line_end   out  1      high while h_cnt == H_TOTAL-1
//   frame_end  out  1      high while at the last pixel of the frame
//   frame_cnt  out  8      completed frames (VGA_FRAME_CNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CNT_W    = 16
) (
    input  logic             clk_25MHz,
    input  logic             rst,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_end
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0]       frame_cnt
`endif
);

    // ------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_FIRST = H_ACTIVE + H_FP;
    localparam int H_SYNC_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int V_SYNC_FIRST = V_ACTIVE + V_FP;
    localparam int V_SYNC_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    // The largest count must be representable in CNT_W bits.
    if ((longint'(H_TOTAL) - 1) >= (longint'(1) << CNT_W)) begin : g_h_width_check
        $error("vga_timing_gen: H_TOTAL-1 = %0d does not fit in CNT_W = %0d bits",
               H_TOTAL - 1, CNT_W);
    end
    if ((longint'(V_TOTAL) - 1) >= (longint'(1) << CNT_W)) begin : g_v_width_check
        $error("vga_timing_gen: V_TOTAL-1 = %0d does not fit in CNT_W = %0d bits",
               V_TOTAL - 1, CNT_W);
    end

    // Same constants at counter width, so every compare is width-matched.
    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_C     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_LO_C = CNT_W'(H_SYNC_FIRST);
    localparam logic [CNT_W-1:0] H_SYNC_HI_C = CNT_W'(H_SYNC_LAST);
    localparam logic [CNT_W-1:0] V_SYNC_LO_C = CNT_W'(V_SYNC_FIRST);
    localparam logic [CNT_W-1:0] V_SYNC_HI_C = CNT_W'(V_SYNC_LAST);

    // ------------------------------------------------------------------
    // Next-position logic
    // ------------------------------------------------------------------
    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    // Decodes that travel with the next position into the output flops.
    logic             hsync_active_next;
    logic             vsync_active_next;
    logic             video_on_next;
    logic             line_end_next;
    logic             frame_end_next;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);

        h_next = h_wrap ? '0 : h_cnt + 1'b1;

        // The line counter only moves on the horizontal wrap.
        v_next = v_cnt;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v_cnt + 1'b1;
        end

        // Decoding the next position (not the current one) makes each
        // registered flag describe the same pixel as h_cnt/v_cnt.
        hsync_active_next = (h_next >= H_SYNC_LO_C) && (h_next <= H_SYNC_HI_C);
        // v_next only changes when h_next becomes 0, so vsync edges
        // automatically fall on line boundaries.
        vsync_active_next = (v_next >= V_SYNC_LO_C) && (v_next <= V_SYNC_HI_C);
        video_on_next     = (h_next < H_ACT_C) && (v_next < V_ACT_C);
        line_end_next     = (h_next == H_LAST);
        frame_end_next    = (h_next == H_LAST) && (v_next == V_LAST);
    end

    // ------------------------------------------------------------------
    // Counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            hsync     <= ~H_POL;
            vsync     <= ~V_POL;
            video_on  <= 1'b1;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else if (pix_en) begin
            h_cnt     <= h_next;
            v_cnt     <= v_next;
            hsync     <= hsync_active_next ? H_POL : ~H_POL;
            vsync     <= vsync_active_next ? V_POL : ~V_POL;
            video_on  <= video_on_next;
            line_end  <= line_end_next;
            frame_end <= frame_end_next;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    // ------------------------------------------------------------------
    // Frame counter: steps on the edge that wraps the last pixel of the
    // frame back to (0,0); wraps naturally from 255 to 0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share one clock: dut_a with default 640x480 geometry and
// active-low syncs, dut_b with an 8/2/2/2 x 4/1/1/1 geometry, active-high
// syncs and a 4-bit count width. A stimulus process drives each instance's
// rst/pix_en and, after every edge, pushes the expected outputs into a
// per-instance queue; a monitor pops and compares on the falling edge.
// Directed checkpoints with hand-computed values are added along the way.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        von;
        logic        le;
        logic        fe;
        logic [7:0]  fc;
    } out_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut_a: default geometry
    logic        rst_a, en_a;
    logic [15:0] h_a, v_a;
    logic        hs_a, vs_a, von_a, le_a, fe_a;
    // dut_b: small geometry, inverted polarity
    logic        rst_b, en_b;
    logic [3:0]  h_b, v_b;
    logic        hs_b, vs_b, von_b, le_b, fe_b;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0]  fc_a, fc_b;
`endif

    vga_timing_gen dut_a (
        .clk_25MHz (clk),
        .rst       (rst_a),
        .pix_en    (en_a),
        .h_cnt     (h_a),
        .v_cnt     (v_a),
        .hsync     (hs_a),
        .vsync     (vs_a),
        .video_on  (von_a),
        .line_end  (le_a),
        .frame_end (fe_a)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt (fc_a)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4)
    ) dut_b (
        .clk_25MHz (clk),
        .rst       (rst_b),
        .pix_en    (en_b),
        .h_cnt     (h_b),
        .v_cnt     (v_b),
        .hsync     (hs_b),
        .vsync     (vs_b),
        .video_on  (von_b),
        .line_end  (le_b),
        .frame_end (fe_b)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt (fc_b)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;

    out_t qa[$];
    out_t qb[$];

    // Reference positions held by the bench.
    int mh_a = 0, mv_a = 0, mfc_a = 0;
    int mh_b = 0, mv_b = 0, mfc_b = 0;

    // Expected outputs for a raster position, from the geometry alone.
    function automatic out_t model_out(int h, int v, int fc,
                                       int ha, int hfp, int hsw, int hbp,
                                       int va, int vfp, int vsw, int vbp,
                                       bit hpol, bit vpol);
        out_t o;
        o.h   = 16'(h);
        o.v   = 16'(v);
        o.hs  = (h >= ha + hfp && h < ha + hfp + hsw) ? hpol : ~hpol;
        o.vs  = (v >= va + vfp && v < va + vfp + vsw) ? vpol : ~vpol;
        o.von = (h < ha) && (v < va);
        o.le  = (h == ha + hfp + hsw + hbp - 1);
        o.fe  = o.le && (v == va + vfp + vsw + vbp - 1);
`ifdef VGA_FRAME_CNT_EN
        o.fc  = 8'(fc);
`else
        o.fc  = 8'd0 + 8'(fc & 0);
`endif
        return o;
    endfunction

    function automatic out_t exp_a();
        return model_out(mh_a, mv_a, mfc_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    endfunction

    function automatic out_t exp_b();
        return model_out(mh_b, mv_b, mfc_b, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
    endfunction

    task automatic step(inout int h, inout int v, inout int fc,
                        input int htot, input int vtot, input bit r, input bit e);
        if (r) begin
            h = 0; v = 0; fc = 0;
        end else if (e) begin
            if (h == htot - 1) begin
                h = 0;
                if (v == vtot - 1) begin
                    v  = 0;
                    fc = (fc + 1) % 256;
                end else begin
                    v = v + 1;
                end
            end else begin
                h = h + 1;
            end
        end
    endtask

    // One clock edge: advance both models with the inputs seen at the edge
    // and queue what each DUT should show afterwards.
    task automatic tick();
        @(posedge clk);
        #1;
        step(mh_a, mv_a, mfc_a, 800, 525, rst_a, en_a);
        step(mh_b, mv_b, mfc_b, 14, 7, rst_b, en_b);
        qa.push_back(exp_a());
        qb.push_back(exp_b());
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_val(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp(string name, out_t act, out_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t: got h=%0d v=%0d hs=%b vs=%b von=%b le=%b fe=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b von=%b le=%b fe=%b fc=%0d",
                     name, $time, act.h, act.v, act.hs, act.vs, act.von, act.le, act.fe, act.fc,
                     exp.h, exp.v, exp.hs, exp.vs, exp.von, exp.le, exp.fe, exp.fc);
        end
    endtask

    // Monitor: one comparison per DUT per clock, away from the active edge.
    always @(negedge clk) begin
        out_t act, exp;
        if (qa.size() > 0) begin
            exp = qa.pop_front();
            act = '0;
            act.h = h_a; act.v = v_a; act.hs = hs_a; act.vs = vs_a;
            act.von = von_a; act.le = le_a; act.fe = fe_a;
`ifdef VGA_FRAME_CNT_EN
            act.fc = fc_a;
`endif
            cmp("scoreboard_a", act, exp);
        end
        if (qb.size() > 0) begin
            exp = qb.pop_front();
            act = '0;
            act.h = 16'(h_b); act.v = 16'(v_b); act.hs = hs_b; act.vs = vs_b;
            act.von = von_b; act.le = le_b; act.fe = fe_b;
`ifdef VGA_FRAME_CNT_EN
            act.fc = fc_b;
`endif
            cmp("scoreboard_b", act, exp);
        end
    end

    initial begin
        int n_low, first_low, last_low, n_voff;
        int n_hs, n_vs, n_von, n_fe, first_fe, prev_fe;

        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        ticks(2);

        // Reset values of dut_a (active-low syncs idle high).
        check_val("rst_a_h", int'(h_a), 0);
        check_val("rst_a_video_on", int'(von_a), 1);
        check_val("rst_a_hsync", int'(hs_a), 1);
        check_val("rst_a_line_end", int'(le_a), 0);
        // Reset values of dut_b (active-high syncs idle low).
        check_val("rst_b_hsync", int'(hs_b), 0);
        check_val("rst_b_vsync", int'(vs_b), 0);

        // ---- dut_a: first line, wrap into line 1 ----
        rst_a = 1'b0; en_a = 1'b1;
        ticks(799);
        check_val("a_h_at_799", int'(h_a), 799);
        check_val("a_v_at_799", int'(v_a), 0);
        check_val("a_line_end_at_799", int'(le_a), 1);
        tick();
        check_val("a_h_after_wrap", int'(h_a), 0);
        check_val("a_v_after_wrap", int'(v_a), 1);
        check_val("a_line_end_after_wrap", int'(le_a), 0);

        // ---- dut_a: sync and blanking windows over line 1 ----
        n_low = 0; first_low = -1; last_low = -1; n_voff = 0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (!hs_a) begin
                n_low++;
                if (first_low < 0) first_low = int'(h_a);
                last_low = int'(h_a);
            end
            if (!von_a) n_voff++;
        end
        check_val("a_hsync_low_clks", n_low, 96);
        check_val("a_hsync_first_low_h", first_low, 656);
        check_val("a_hsync_last_low_h", last_low, 751);
        check_val("a_video_off_clks", n_voff, 160);

        // ---- dut_a: pix_en alternating, one line takes 1600 clocks ----
        for (int i = 0; i < 1600; i++) begin
            en_a = (i % 2 == 0);
            tick();
        end
        check_val("a_h_after_gated_line", int'(h_a), 0);
        check_val("a_v_after_gated_line", int'(v_a), 3);
        en_a = 1'b1;

        // ---- dut_a: asynchronous reset mid-line ----
        ticks(700);
        check_val("a_h_before_async_rst", int'(h_a), 700);
        #2;
        rst_a = 1'b1;
        mh_a = 0; mv_a = 0; mfc_a = 0;
        qa[qa.size() - 1] = exp_a();
        #1;
        check_val("a_async_rst_h", int'(h_a), 0);
        check_val("a_async_rst_v", int'(v_a), 0);
        check_val("a_async_rst_hsync", int'(hs_a), 1);
        check_val("a_async_rst_video_on", int'(von_a), 1);
        ticks(2);
        rst_a = 1'b0;
        #1;
        check_val("a_h_after_release_no_edge", int'(h_a), 0);
        tick();
        check_val("a_h_first_edge_after_release", int'(h_a), 1);
        check_val("a_v_first_edge_after_release", int'(v_a), 0);
        en_a = 1'b0;

        // ---- dut_b: three full frames (14 x 7 = 98 clocks each) ----
        rst_b = 1'b0; en_b = 1'b1;
        n_hs = 0; n_vs = 0; n_von = 0; n_fe = 0; first_fe = -1; prev_fe = -1;
        for (int i = 1; i <= 294; i++) begin
            tick();
            if (hs_b) n_hs++;
            if (vs_b) n_vs++;
            if (von_b) n_von++;
            if (fe_b) begin
                n_fe++;
                if (first_fe < 0) first_fe = i;
                else check_val("b_frame_period", i - prev_fe, 98);
                prev_fe = i;
            end
        end
        check_val("b_hsync_active_clks", n_hs, 42);
        check_val("b_vsync_active_clks", n_vs, 42);
        check_val("b_video_on_clks", n_von, 96);
        check_val("b_frame_end_pulses", n_fe, 3);
        check_val("b_first_frame_end_edge", first_fe, 97);

        // ---- dut_b: asynchronous reset at (10,3) ----
        ticks(52);
        check_val("b_h_before_async_rst", int'(h_b), 10);
        check_val("b_v_before_async_rst", int'(v_b), 3);
        check_val("b_hsync_before_async_rst", int'(hs_b), 1);
        #2;
        rst_b = 1'b1;
        mh_b = 0; mv_b = 0; mfc_b = 0;
        qb[qb.size() - 1] = exp_b();
        #1;
        check_val("b_async_rst_h", int'(h_b), 0);
        check_val("b_async_rst_hsync", int'(hs_b), 0);
        check_val("b_async_rst_video_on", int'(von_b), 1);
`ifdef VGA_FRAME_CNT_EN
        check_val("b_async_rst_frame_cnt", int'(fc_b), 0);
`endif
        tick();
        rst_b = 1'b0;
        tick();
        check_val("b_h_first_edge_after_release", int'(h_b), 1);
        check_val("b_v_first_edge_after_release", int'(v_b), 0);

`ifdef VGA_FRAME_CNT_EN
        // ---- dut_b: frame counter wrap ----
        ticks(96);
        check_val("b_frame_end_before_wrap", int'(fe_b), 1);
        check_val("b_frame_cnt_before_wrap", int'(fc_b), 0);
        tick();
        check_val("b_frame_cnt_after_wrap", int'(fc_b), 1);
        ticks(254 * 98);
        check_val("b_frame_cnt_255", int'(fc_b), 255);
        ticks(98);
        check_val("b_frame_cnt_rollover", int'(fc_b), 0);
`endif

        // Let the monitor drain the last queued entries.
        @(negedge clk);
        #1;
        check_val("queues_drained", qa.size() + qb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
